dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//   Shares the single-port data memory (mem1) between two requesters: the CPU
//   load/store port (req 0) and the debug/loader port (req 1).
//   - Round-robin arbitration; at most one access issued per cycle.
//   - Read data returns one cycle later, steered to the owning requester.
//   - Keeps saturating stall counters for performance checks in the testbench.
//   - Sits between the mips datapath (MemWr/ALU address/DM) and mem1.
// PARAMETERS
//   ADDR_W   16  byte-address width (64 KiB data space)
//   CNT_W    16  stall-counter width (saturating)
// PORTS
//   Clk          in   1       single clock; all logic on posedge Clk
//   Reset        in   1       synchronous, active-high
//   req_i        in   2       per-requester access request, held until granted
//   we_i         in   2x4     per-requester byte write enables, MSB = byte addr+0 (big-endian); 0000 = read
//   addr_i       in   2xADDR_W per-requester byte address (word aligned, [1:0] ignored)
//   wdata_i      in   2x32    per-requester write data
//   gnt_o        out  2       one-hot; request accepted this cycle
//   rvalid_o     out  2       one-hot; read data valid for that requester
//   rdata_o      out  32      read data, shared bus, qualified by rvalid_o
//   mem_en_o     out  1       memory access strobe
//   mem_we_o     out  4       byte write enables to memory
//   mem_addr_o   out  ADDR_W  word-aligned address to memory
//   mem_wdata_o  out  32      write data to memory
//   mem_rdata_i  in   32      memory read data, valid the cycle after a read strobe
//   stall_cnt_o  out  2xCNT_W cycles each requester had req high without gnt
//   lock_o       out  1       debug lock active (0 when the lock feature is compiled out)
// BEHAVIOUR
//   - Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, mem_en_o=0, mem_we_o=0,
//     mem_addr_o=0, mem_wdata_o=0, stall counters=0, lock_o=0.
//   - Reset also sets last_gnt=1, so req 0 (CPU) wins the first tie.
//   - Reset mid-read drops the pending rvalid; no response is issued afterwards.
//   - Grant is combinational from req_i and registered state:
//       one request -> grant it
//       both        -> grant ~last_gnt
//       none        -> no grant; last_gnt unchanged
//   - mem_* outputs are combinational copies of the granted requester's fields.
//     mem_en_o = |gnt_o.
//   - Read (we=0000) granted in cycle N -> rvalid_o[owner]=1 in cycle N+1,
//     with rdata_o = mem_rdata_i.
//   - Write -> no rvalid. Owner and read flag are registered at grant.
//   - Back-to-back grants are allowed every cycle, so a response and a new grant
//     can coincide.
//   - Fairness: a requester that is continuously asserting waits at most 1 cycle
//     (unlocked).
//   - Stall counter[i] increments when req_i[i] & ~gnt_o[i], and saturates at
//     all-ones.
//   - Deasserting req without a grant is legal: it withdraws the request.
//   - Bits addr_i[1:0] are forced to 0 on mem_addr_o.
//   - Requester address space wraps at 2^ADDR_W; no bounds check.
// CONFIGURATION
//   DM_ARB_LOCK_EN defined:
//     - Adds input dbg_lock_i.
//     - While req 1 holds the grant and dbg_lock_i=1, lock_o=1 and req 1 keeps
//       priority on every cycle; CPU starvation is permitted.
//     - Lock releases when dbg_lock_i=0; the next tie then goes to the CPU.
//   DM_ARB_LOCK_EN undefined:
//     - No dbg_lock_i port; lock_o tied to 0.
//     - Pure round-robin.
// STRUCTURE
//   - Shared package dm_arb_pkg:
//       REQ_CPU=0, REQ_DBG=1
//       BE_READ=4'b0000, BE_WORD=4'b1111
//       typedef for the {we, addr, wdata} request bundle
//   - One sub-module: sat_counter (CNT_W), instantiated twice for the stall counters.
//   - Arbitration, response pipeline register and lock logic live in the top.
// TESTING
//   1 Reset held 2 cycles, then released, no requests -> all outputs 0,
//     stall counts 0.
//   2 CPU word write: addr=16'hffec, data=0000_0005, we=1111; then read
//     -> gnt[0] on both; the read returns rvalid[0]=1 one cycle later,
//     rdata=5.
//   3 Both request reads continuously for 6 cycles -> grants alternate
//     0,1,0,1,0,1; each stall count = 3.
//   4 Byte write we=0100 to addr 16'hfff2 (low bits ignored -> 16'hfff0),
//     data 0000_AB00 -> word read back shows only byte 1 changed.
//   5 Reset asserted the cycle after a read grant -> no rvalid ever issued;
//     the CPU wins the first grant after reset.
//   6 (DM_ARB_LOCK_EN) dbg_lock_i=1 with both requesting for 5 cycles
//     -> gnt=10 every cycle; stall[0]=5; the first tie after release goes
//     to the CPU.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared constants and request bundle for the data-memory port arbiter
package dm_arb_pkg;

  localparam int DM_ADDR_W = 16;

  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  localparam logic [3:0] BE_READ = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [3:0]           we;
    logic [DM_ADDR_W-1:0] addr;
    logic [31:0]          wdata;
  } dm_req_t;

  function automatic logic is_read(input logic [3:0] we);
    return we == BE_READ;
  endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// rtl/dm_port_arbiter_if.sv - requester and mem1 bus bundle; slave = arbiter side, master = requesters/memory
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 16
) ();

  logic [1:0]             req_i;
  logic [1:0][3:0]        we_i;
  logic [1:0][ADDR_W-1:0] addr_i;
  logic [1:0][31:0]       wdata_i;
  logic [1:0]             gnt_o;
  logic [1:0]             rvalid_o;
  logic [31:0]            rdata_o;
  logic                   mem_en_o;
  logic [3:0]             mem_we_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic [31:0]            mem_wdata_o;
  logic [31:0]            mem_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/dm_port_arbiter_sat_counter.sv
// rtl/dm_port_arbiter_sat_counter.sv - saturating up-counter used for per-requester stall counts
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - round-robin sharing of mem1 between CPU (req 0) and debug/loader (req 1)
// Optional debug lock compiled in with DM_ARB_LOCK_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  dm_port_arbiter_if.slave      bus,
`ifdef DM_ARB_LOCK_EN
  input  logic                  dbg_lock_i,
`endif
  output logic [1:0][CNT_W-1:0] stall_cnt_o,
  output logic                  lock_o
);

  logic        last_gnt_q, last_gnt_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_owner_q, rd_owner_d;
  logic [1:0]  gnt;
  logic        lock_hold;
  dm_req_t     req [2];
  dm_req_t     sel;
  logic [ADDR_W-1:0] sel_addr;
  logic        unused_addr_bits;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req[i].we    = bus.we_i[i];
      req[i].addr  = DM_ADDR_W'(bus.addr_i[i]);
      req[i].wdata = bus.wdata_i[i];
    end
  end

  // The lock only holds a grant the debug port already owns; it never preempts the CPU.
`ifdef DM_ARB_LOCK_EN
  assign lock_hold = dbg_lock_i && (last_gnt_q == 1'(REQ_DBG)) && bus.req_i[REQ_DBG];
  assign lock_o    = dbg_lock_i && gnt[REQ_DBG];
`else
  assign lock_hold = 1'b0;
  assign lock_o    = 1'b0;
`endif

  always_comb begin
    gnt = 2'b00;
    if (!Reset) begin
      if (lock_hold)          gnt = 2'b10;
      else if (&bus.req_i)    gnt = last_gnt_q ? 2'b01 : 2'b10;
      else                    gnt = bus.req_i;
    end
  end

  always_comb begin
    sel = '0;
    if (gnt[REQ_DBG])      sel = req[REQ_DBG];
    else if (gnt[REQ_CPU]) sel = req[REQ_CPU];
  end

  assign sel_addr         = ADDR_W'(sel.addr);
  assign unused_addr_bits = ^sel_addr[1:0];

  assign bus.gnt_o       = gnt;
  assign bus.mem_en_o    = |gnt;
  assign bus.mem_we_o    = sel.we;
  assign bus.mem_addr_o  = {sel_addr[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata_o = sel.wdata;

  always_comb begin
    last_gnt_d = (|gnt) ? gnt[REQ_DBG] : last_gnt_q;
    rd_valid_d = (|gnt) && is_read(sel.we);
    rd_owner_d = gnt[REQ_DBG];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_gnt_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Reset masks a response already in flight so nothing escapes during reset.
  assign bus.rvalid_o = (rd_valid_q && !Reset) ? (rd_owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata_o  = (|bus.rvalid_o) ? bus.mem_rdata_i : 32'h0;

  for (genvar g = 0; g < 2; g++) begin : g_stall
    sat_counter #(.CNT_W(CNT_W)) u_stall (
      .clk_i (Clk),
      .rst_i (Reset),
      .inc_i (bus.req_i[g] & ~gnt[g]),
      .cnt_o (stall_cnt_o[g])
    );
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - directed self-checking bench for dm_port_arbiter with a behavioural mem1
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 3;

  logic Clk = 1'b0;
  logic Reset;
  logic dbg_lock_i;
  logic [1:0][CNT_W-1:0] stall_cnt_o;
  logic lock_o;
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem [16384];

  dm_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dm_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .bus         (bus.slave),
`ifdef DM_ARB_LOCK_EN
    .dbg_lock_i  (dbg_lock_i),
`endif
    .stall_cnt_o (stall_cnt_o),
    .lock_o      (lock_o)
  );

  always #5 Clk = ~Clk;

  // mem1: we[3] is byte addr+0 (bits 31:24), read data one cycle after the strobe.
  always @(posedge Clk) begin
    if (bus.mem_en_o) begin
      bus.mem_rdata_i <= mem[bus.mem_addr_o[15:2]];
      for (int k = 0; k < 4; k++)
        if (bus.mem_we_o[k]) mem[bus.mem_addr_o[15:2]][8*k +: 8] <= bus.mem_wdata_o[8*k +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic r, input logic [3:0] we,
                       input logic [15:0] a, input logic [31:0] d);
    bus.req_i[i]   = r;
    bus.we_i[i]    = we;
    bus.addr_i[i]  = a;
    bus.wdata_i[i] = d;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic settle;
    @(negedge Clk);
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    drive(0, 1'b0, BE_READ, 16'h0, 32'h0);
    drive(1, 1'b0, BE_READ, 16'h0, 32'h0);
    repeat (n) tick();
    Reset = 1'b0;
  endtask

  logic [1:0] exp_alt [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    dbg_lock_i = 1'b0;

    // 1: reset state
    do_reset(2);
    settle();
    check_eq("rst_gnt",    32'(bus.gnt_o), 32'h0);
    check_eq("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
    check_eq("rst_rdata",  bus.rdata_o, 32'h0);
    check_eq("rst_mem_en", 32'(bus.mem_en_o), 32'h0);
    check_eq("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr_o), 32'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    check_eq("rst_stall0", 32'(stall_cnt_o[0]), 32'h0);
    check_eq("rst_stall1", 32'(stall_cnt_o[1]), 32'h0);
    check_eq("rst_lock",   32'(lock_o), 32'h0);

    // 2: CPU word write then read back
    tick();
    drive(0, 1'b1, BE_WORD, 16'hffec, 32'h0000_0005);
    settle();
    check_eq("wr_gnt",      32'(bus.gnt_o), 32'h1);
    check_eq("wr_mem_en",   32'(bus.mem_en_o), 32'h1);
    check_eq("wr_mem_we",   32'(bus.mem_we_o), 32'hf);
    check_eq("wr_mem_addr", 32'(bus.mem_addr_o), 32'hffec);
    check_eq("wr_mem_wdata", bus.mem_wdata_o, 32'h5);
    tick();
    drive(0, 1'b1, BE_READ, 16'hffec, 32'h0);
    settle();
    check_eq("rd_gnt",         32'(bus.gnt_o), 32'h1);
    check_eq("wr_no_rvalid",   32'(bus.rvalid_o), 32'h0);
    tick();
    drive(0, 1'b0, BE_READ, 16'h0, 32'h0);
    settle();
    check_eq("rd_rvalid", 32'(bus.rvalid_o), 32'h1);
    check_eq("rd_rdata",  bus.rdata_o, 32'h5);
    tick();
    settle();
    check_eq("rd_rvalid_off", 32'(bus.rvalid_o), 32'h0);

    // 3: continuous contention, then counter saturation at 7
    do_reset(1);
    drive(0, 1'b1, BE_READ, 16'h0010, 32'h0);
    drive(1, 1'b1, BE_READ, 16'h0020, 32'h0);
    for (int c = 0; c < 6; c++) begin
      settle();
      check_eq($sformatf("alt_gnt%0d", c), 32'(bus.gnt_o), 32'(exp_alt[c]));
      tick();
    end
    settle();
    check_eq("alt_stall0", 32'(stall_cnt_o[0]), 32'd3);
    check_eq("alt_stall1", 32'(stall_cnt_o[1]), 32'd3);
    check_eq("alt_rvalid_dbg", 32'(bus.rvalid_o), 32'h2);
    repeat (10) tick();
    settle();
    check_eq("sat_stall0", 32'(stall_cnt_o[0]), 32'd7);
    check_eq("sat_stall1", 32'(stall_cnt_o[1]), 32'd7);

    // 4: byte write through the debug port, low address bits ignored
    do_reset(1);
    drive(0, 1'b1, BE_WORD, 16'hfff0, 32'h1122_3344);
    tick();
    drive(0, 1'b0, BE_READ, 16'h0, 32'h0);
    drive(1, 1'b1, 4'b0100, 16'hfff2, 32'h0000_AB00);
    settle();
    check_eq("bw_gnt",      32'(bus.gnt_o), 32'h2);
    check_eq("bw_mem_addr", 32'(bus.mem_addr_o), 32'hfff0);
    check_eq("bw_mem_we",   32'(bus.mem_we_o), 32'h4);
    check_eq("bw_mem_wdata", bus.mem_wdata_o, 32'h0000_AB00);
    tick();
    drive(1, 1'b1, BE_READ, 16'hfff0, 32'h0);
    tick();
    drive(1, 1'b0, BE_READ, 16'h0, 32'h0);
    settle();
    check_eq("bw_rvalid", 32'(bus.rvalid_o), 32'h2);
    check_eq("bw_rdata",  bus.rdata_o, 32'h1100_3344);

    // 5: reset right after a read grant swallows the response
    do_reset(1);
    drive(0, 1'b1, BE_READ, 16'hffec, 32'h0);
    settle();
    check_eq("rr_gnt", 32'(bus.gnt_o), 32'h1);
    tick();
    Reset = 1'b1;
    drive(0, 1'b0, BE_READ, 16'h0, 32'h0);
    settle();
    check_eq("rr_rvalid_a", 32'(bus.rvalid_o), 32'h0);
    tick();
    settle();
    check_eq("rr_rvalid_b", 32'(bus.rvalid_o), 32'h0);
    tick();
    Reset = 1'b0;
    drive(0, 1'b1, BE_READ, 16'h0010, 32'h0);
    drive(1, 1'b1, BE_READ, 16'h0020, 32'h0);
    settle();
    check_eq("rr_first_gnt", 32'(bus.gnt_o), 32'h1);
    check_eq("rr_rvalid_c",  32'(bus.rvalid_o), 32'h0);
    tick();

`ifdef DM_ARB_LOCK_EN
    // 6: debug lock holds the port, CPU wins the first tie after release
    do_reset(1);
    drive(0, 1'b1, BE_READ, 16'h0010, 32'h0);
    settle();
    check_eq("lk_pre_gnt", 32'(bus.gnt_o), 32'h1);
    tick();
    drive(1, 1'b1, BE_READ, 16'h0020, 32'h0);
    dbg_lock_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      check_eq($sformatf("lk_gnt%0d", c), 32'(bus.gnt_o), 32'h2);
      check_eq($sformatf("lk_lock%0d", c), 32'(lock_o), 32'h1);
      tick();
    end
    dbg_lock_i = 1'b0;
    settle();
    check_eq("lk_stall0", 32'(stall_cnt_o[0]), 32'd5);
    check_eq("lk_stall1", 32'(stall_cnt_o[1]), 32'd0);
    check_eq("lk_rel_gnt", 32'(bus.gnt_o), 32'h1);
    check_eq("lk_rel_lock", 32'(lock_o), 32'h0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
